// File: rtl/as_slave_bpi_pkg.sv
// Shared types and constants for the BPI Wishbone responder (package as_pack).

package as_pack;

    typedef enum logic [1:0] {BPI_IDLE, BPI_WAIT, BPI_ACK} bpi_state_t;

    localparam int unsigned bpi_sel_width = 8;
    localparam int unsigned bpi_wait_max  = 15;

endpackage

// File: rtl/as_slave_bpi_if.sv
// Wishbone-classic BPI bus bundle; wb_s_err_o exists only with AS_SLAVE_BPI_ERR_EN defined.

interface as_slave_bpi_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    import as_pack::*;

    logic [ADDR_W-1:0]        wb_s_addr_i;
    logic [DATA_W-1:0]        wb_s_dat_i;
    logic [DATA_W-1:0]        wb_s_dat_o;
    logic                     wb_s_we_i;
    logic [bpi_sel_width-1:0] wb_s_sel_i;
    logic                     wb_s_stb_i;
    logic                     wb_s_cyc_i;
    logic                     wb_s_ack_o;
`ifdef AS_SLAVE_BPI_ERR_EN
    logic                     wb_s_err_o;
`endif

    modport master (
        output wb_s_addr_i, wb_s_dat_i, wb_s_we_i, wb_s_sel_i, wb_s_stb_i, wb_s_cyc_i,
        input  wb_s_dat_o, wb_s_ack_o
`ifdef AS_SLAVE_BPI_ERR_EN
        , input wb_s_err_o
`endif
    );

    modport slave (
        input  wb_s_addr_i, wb_s_dat_i, wb_s_we_i, wb_s_sel_i, wb_s_stb_i, wb_s_cyc_i,
        output wb_s_dat_o, wb_s_ack_o
`ifdef AS_SLAVE_BPI_ERR_EN
        , output wb_s_err_o
`endif
    );

endinterface

// File: rtl/as_bpi_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered, resettable read port.

module as_bpi_ram
    import as_pack::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IDX_W-1:0]         addr_i,
    input  logic [bpi_sel_width-1:0] be_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < int'(bpi_sel_width); n++) begin
            if (be_i[n]) begin
                mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
            end
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/as_slave_bpi.sv
// BPI Wishbone-classic responder: captures a request, waits WAIT_STATES cycles, acks from RAM.
// Define AS_SLAVE_BPI_ERR_EN to answer out-of-range addresses with wb_s_err_o instead of wrapping.

module as_slave_bpi
    import as_pack::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    as_slave_bpi_if.slave wb_s
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(bpi_wait_max + 1);

    bpi_state_t               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q;
    logic                     we_q, oor_q;
    logic [bpi_sel_width-1:0] sel_q;
    logic [DATA_W-1:0]        dat_q;
    logic                     ack_q, err_q;

    logic                     req, bus_oor, enter_ack, cur_we, cur_oor, ram_re;
    logic [IDX_W-1:0]         bus_idx, cur_idx;
    logic [bpi_sel_width-1:0] ram_be;

    assign req     = wb_s.wb_s_cyc_i & wb_s.wb_s_stb_i;
    assign bus_idx = wb_s.wb_s_addr_i[IDX_W+2:3];

`ifdef AS_SLAVE_BPI_ERR_EN
    assign bus_oor = |wb_s.wb_s_addr_i[ADDR_W-1:IDX_W+3];
`else
    assign bus_oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BPI_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = BPI_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = BPI_ACK;
                    end
                end
            end
            BPI_WAIT: begin
                if (!wb_s.wb_s_cyc_i) begin
                    state_d = BPI_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = BPI_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BPI_ACK:  state_d = BPI_IDLE;
            default:  state_d = BPI_IDLE;
        endcase
    end

    // In IDLE the request is not captured yet, so the RAM reads straight from the bus.
    always_comb begin
        cur_idx   = (state_q == BPI_IDLE) ? bus_idx : idx_q;
        cur_we    = (state_q == BPI_IDLE) ? wb_s.wb_s_we_i : we_q;
        cur_oor   = (state_q == BPI_IDLE) ? bus_oor : oor_q;
        enter_ack = (state_d == BPI_ACK) && (state_q != BPI_ACK) && !rst_i;
        ram_re    = enter_ack && !cur_we && !cur_oor;
        ram_be    = (state_q == BPI_ACK && we_q && !oor_q && !rst_i) ? sel_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BPI_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_ack && !cur_oor;
            err_q   <= enter_ack && cur_oor;
            if (state_q == BPI_IDLE && req) begin
                idx_q <= bus_idx;
                we_q  <= wb_s.wb_s_we_i;
                oor_q <= bus_oor;
                sel_q <= wb_s.wb_s_sel_i;
                dat_q <= wb_s.wb_s_dat_i;
            end
        end
    end

    as_bpi_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (cur_idx),
        .be_i    (ram_be),
        .wdata_i (dat_q),
        .re_i    (ram_re),
        .rdata_o (wb_s.wb_s_dat_o)
    );

    assign wb_s.wb_s_ack_o = ack_q;
`ifdef AS_SLAVE_BPI_ERR_EN
    assign wb_s.wb_s_err_o = err_q;
`endif

endmodule

// File: tb/tb_as_slave_bpi.sv
// Directed bench for as_slave_bpi: three instances with WAIT_STATES 0, 1 and 3 share one driver.

module tb_as_slave_bpi;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr, wdat;
    logic [7:0]  sel;
    logic        we, cyc, stb;
    int unsigned dsel;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    as_slave_bpi_if #(.ADDR_W(64), .DATA_W(64)) bus0 ();
    as_slave_bpi_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    as_slave_bpi_if #(.ADDR_W(64), .DATA_W(64)) bus3 ();

    assign bus0.wb_s_addr_i = addr;
    assign bus0.wb_s_dat_i  = wdat;
    assign bus0.wb_s_we_i   = we;
    assign bus0.wb_s_sel_i  = sel;
    assign bus0.wb_s_cyc_i  = cyc & (dsel == 0);
    assign bus0.wb_s_stb_i  = stb & (dsel == 0);
    assign bus1.wb_s_addr_i = addr;
    assign bus1.wb_s_dat_i  = wdat;
    assign bus1.wb_s_we_i   = we;
    assign bus1.wb_s_sel_i  = sel;
    assign bus1.wb_s_cyc_i  = cyc & (dsel == 1);
    assign bus1.wb_s_stb_i  = stb & (dsel == 1);
    assign bus3.wb_s_addr_i = addr;
    assign bus3.wb_s_dat_i  = wdat;
    assign bus3.wb_s_we_i   = we;
    assign bus3.wb_s_sel_i  = sel;
    assign bus3.wb_s_cyc_i  = cyc & (dsel == 3);
    assign bus3.wb_s_stb_i  = stb & (dsel == 3);

    as_slave_bpi #(.WAIT_STATES(0)) u_ws0 (.clk_i(clk), .rst_i(rst), .wb_s(bus0));
    as_slave_bpi #(.WAIT_STATES(1)) u_ws1 (.clk_i(clk), .rst_i(rst), .wb_s(bus1));
    as_slave_bpi #(.WAIT_STATES(3)) u_ws3 (.clk_i(clk), .rst_i(rst), .wb_s(bus3));

    logic        ack_m, err_m;
    logic [63:0] rdat_m;
    assign ack_m  = (dsel == 0) ? bus0.wb_s_ack_o : (dsel == 1) ? bus1.wb_s_ack_o : bus3.wb_s_ack_o;
    assign rdat_m = (dsel == 0) ? bus0.wb_s_dat_o : (dsel == 1) ? bus1.wb_s_dat_o : bus3.wb_s_dat_o;
`ifdef AS_SLAVE_BPI_ERR_EN
    assign err_m  = (dsel == 0) ? bus0.wb_s_err_o : (dsel == 1) ? bus1.wb_s_err_o : bus3.wb_s_err_o;
`else
    assign err_m  = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer; lat counts edges from the request edge to the completion cycle.
    task automatic xfer(input int unsigned d, input logic w, input logic [63:0] a,
                        input logic [63:0] dat, input logic [7:0] s,
                        output int unsigned lat, output logic [63:0] rd,
                        output logic ack_f, output logic err_f);
        logic done;
        @(negedge clk);
        dsel = d; we = w; addr = a; wdat = dat; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            done = ack_m | err_m;
        end
        rd    = rdat_m;
        ack_f = ack_m;
        err_f = err_m;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("single_cycle_resp", {62'd0, ack_m, err_m}, 64'd0);
    endtask

    int unsigned lat;
    logic [63:0] rd;
    logic        ack_f, err_f;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdat = '0; sel = '0; dsel = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ack_ws1", {63'd0, ack_m}, 64'd0);
        check("rst_dat_ws1", rdat_m, 64'd0);

        // Full write then read-back, WAIT_STATES=1
        xfer(1, 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, lat, rd, ack_f, err_f);
        check("wr_lat_ws1", 64'(lat), 64'd2);
        check("wr_ack_ws1", {63'd0, ack_f}, 64'd1);
        xfer(1, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("rd_lat_ws1", 64'(lat), 64'd2);
        check("rd_dat_ws1", rd, 64'h1122334455667788);

        // Low four byte lanes only
        xfer(1, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, lat, rd, ack_f, err_f);
        xfer(1, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("byte_lanes", rd, 64'h11223344AAAAAAAA);

        // sel = 0 acks but leaves the word alone
        xfer(1, 1'b1, 64'h10, 64'h0, 8'h00, lat, rd, ack_f, err_f);
        check("sel0_ack", {63'd0, ack_f}, 64'd1);
        xfer(1, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("sel0_keep", rd, 64'h11223344AAAAAAAA);

        // WAIT_STATES=0: single write, then reads with stb held high
        xfer(0, 1'b1, 64'h8, 64'hCAFEF00D12345678, 8'hFF, lat, rd, ack_f, err_f);
        check("wr_lat_ws0", 64'(lat), 64'd1);
        @(negedge clk);
        dsel = 0; we = 1'b0; addr = 64'h8; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("b2b_ack", {63'd0, ack_m}, (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0) check("b2b_dat", rdat_m, 64'hCAFEF00D12345678);
        end
        cyc = 1'b0; stb = 1'b0;

        // WAIT_STATES=3: seed word 0x20, then abort a write by dropping cyc in WAIT
        xfer(3, 1'b1, 64'h20, 64'h0123456789ABCDEF, 8'hFF, lat, rd, ack_f, err_f);
        check("wr_lat_ws3", 64'(lat), 64'd4);
        @(negedge clk);
        dsel = 3; we = 1'b1; addr = 64'h20; wdat = 64'hDEAD; sel = 8'hFF;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_ack", {63'd0, ack_m}, 64'd0);
        end
        xfer(3, 1'b0, 64'h20, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("abort_rd_lat", 64'(lat), 64'd4);
        check("abort_keep", rd, 64'h0123456789ABCDEF);

        // Reset pulse while in WAIT
        @(negedge clk);
        dsel = 3; we = 1'b1; addr = 64'h20; wdat = 64'hBAD; sel = 8'hFF;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        check("rst_wait_ack", {63'd0, ack_m}, 64'd0);
        check("rst_wait_dat", rdat_m, 64'd0);
        xfer(3, 1'b0, 64'h20, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_dat", rd, 64'h0123456789ABCDEF);

        // Address above the RAM range: err, or wrap to word 0
        xfer(1, 1'b1, 64'h0, 64'h0F0F0F0F0F0F0F0F, 8'hFF, lat, rd, ack_f, err_f);
        xfer(1, 1'b1, 64'h1000, 64'h5555555555555555, 8'hFF, lat, rd, ack_f, err_f);
        check("oor_lat", 64'(lat), 64'd2);
`ifdef AS_SLAVE_BPI_ERR_EN
        check("oor_err", {63'd0, err_f}, 64'd1);
        check("oor_no_ack", {63'd0, ack_f}, 64'd0);
        xfer(1, 1'b0, 64'h0, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("oor_ram_keep", rd, 64'h0F0F0F0F0F0F0F0F);
`else
        check("wrap_ack", {63'd0, ack_f}, 64'd1);
        xfer(1, 1'b0, 64'h0, 64'h0, 8'hFF, lat, rd, ack_f, err_f);
        check("wrap_word0", rd, 64'h5555555555555555);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/as_slave_bpi.md
Name: as_slave_bpi

Overview:
- Wishbone-classic responder (slave) for the BPI data bus: the counterpart of the core's master BPI.
- Accepts single read and write cycles from a master, inserts a configurable number of wait states, and serves them from an internal byte-lane-writable 64-bit RAM.
- Sits between the CPU's data-bus pins (wbdBus*) and on-chip data memory; a second instance can back the instruction bus.

Parameters:
- ADDR_W, 64, width of the byte address from the master.
- DATA_W, 64, data width; fixed to 64 here, so SEL_W = 8.
- DEPTH, 512, number of 64-bit words in the RAM; must be a power of two.
- WAIT_STATES, 1, extra cycles between request sampling and ack; range 0..15.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- wb_s_addr_i  in  ADDR_W  byte address.
- wb_s_dat_i  in  DATA_W  write data from the master.
- wb_s_dat_o  out  DATA_W  read data to the master.
- wb_s_we_i  in  1  1 = write, 0 = read.
- wb_s_sel_i  in  8  byte-lane enables; bit n selects byte n.
- wb_s_stb_i  in  1  strobe.
- wb_s_cyc_i  in  1  bus cycle active.
- wb_s_ack_o  out  1  single-cycle transfer acknowledge.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - FSM goes to IDLE.
  - wb_s_ack_o = 0, wb_s_dat_o = 0, wait counter = 0.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts the transfer; no write is committed.
- Request: valid when wb_s_cyc_i & wb_s_stb_i are both 1 at a clock edge while in IDLE.
  - addr, we, sel and dat_i are captured into registers on that edge.
- Word index = captured addr[$clog2(DEPTH)+2:3].
  - addr[2:0] is ignored.
  - Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- FSM states: IDLE, WAIT, ACK.
  - IDLE -> WAIT when a request is seen and WAIT_STATES > 0; the counter loads WAIT_STATES-1.
  - IDLE -> ACK when a request is seen and WAIT_STATES = 0.
  - WAIT: the counter decrements each cycle; when it reaches 0 the FSM moves to ACK.
  - ACK -> IDLE unconditionally after one cycle.
- wb_s_ack_o is registered and is 1 only while in ACK.
  - Ack rises WAIT_STATES+1 cycles after the request edge.
  - Ack is never high for two consecutive cycles.
- Abort: if wb_s_cyc_i falls while in WAIT, the FSM returns to IDLE next cycle with no ack and no write.
  - Once in ACK, the transfer completes regardless of cyc.
- Write: committed in the ACK cycle. Only bytes with sel[n] = 1 are updated; the other bytes keep their old value.
  - sel = 0 produces an ack with no RAM change.
- Read: wb_s_dat_o is loaded with RAM[word] on the edge that enters ACK, so it is valid while ack = 1.
  - It then holds until the next read; writes do not change wb_s_dat_o.
- Master contract: stb must be low in the cycle after ack.
  - If stb is still high in IDLE, a new request is taken, giving back-to-back transfers with a minimum spacing of WAIT_STATES+2 cycles.
- A read that follows a write to the same word returns the new data (no hazard, since the write commits first).

Optional Feature:
- Macro: AS_SLAVE_BPI_ERR_EN.
- Defined:
  - Adds output port wb_s_err_o (1 bit, reset 0).
  - A request with address bits above the RAM range non-zero asserts err instead of ack, in the same cycle slot ack would have used.
  - No write is committed and wb_s_dat_o is unchanged.
  - ack and err are never both 1.
- Undefined: the port is absent and addresses wrap as above.

Decomposition:
- Package as_pack gets:
  - typedef enum logic [1:0] {BPI_IDLE, BPI_WAIT, BPI_ACK} bpi_state_t;
  - constants bpi_sel_width = 8 and bpi_wait_max = 15.
- One sub-module, as_bpi_ram:
  - single-port synchronous RAM with DEPTH words, byte write-enable[7:0], and registered read data.
  - as_slave_bpi holds the FSM, counter and capture registers.

Test Plan:
- Reset, then WAIT_STATES=1; write addr 0x10, dat 0x1122334455667788, sel 0xFF -> ack exactly 2 cycles after the stb edge, high for 1 cycle; read of 0x10 returns 0x1122334455667788 with ack.
- Byte lanes: write 0xAAAA... with sel 0x0F to word 0x10 -> read gives 0x11223344AAAAAAAA.
- WAIT_STATES=0, back-to-back reads with stb held high -> acks every 2nd cycle; ack never high two cycles in a row.
- Abort: drop cyc in WAIT during a write of 0xDEAD to 0x20 with WAIT_STATES=3 -> no ack, and a later read of 0x20 returns the old value.
- rst_i pulsed during WAIT -> ack=0 and dat_o=0 next cycle; FSM in IDLE; next request serviced normally.
- With AS_SLAVE_BPI_ERR_EN and DEPTH=512, access addr 0x1000 -> err=1 for one cycle, ack=0, RAM unchanged. Without the macro, the same access hits word 0 (wrap).
